ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
//  Pairs with ps2kbd, which receives on the same open-drain clk/data pins.
//  Sits beside ps2kbd in the top level and is driven by a SoC register. busy_o gates the receiver during a send.
// PARAMETERS
//  FREQ_HZ          25_000_000  system clock frequency (Hz)
//  INHIBIT_US       100         clock-inhibit time before the request-to-send (us)
//  FIRST_TIMEOUT_US 15000       max wait for the first device clock falling edge (us)
//  EDGE_TIMEOUT_US  2000        max wait between later falling edges, and for bus idle (us)
//  Cycle counts are X_CYCLES = FREQ_HZ/1_000_000*X_US; counters are sized with $clog2.
// PORTS
//  clk            in   1  system clock
//  reset_n_i      in   1  asynchronous reset, active low
//  tx_data_i      in   8  byte to send
//  tx_valid_i     in   1  request; accepted when tx_valid_i && tx_ready_o
//  tx_ready_o     out  1  1 only in IDLE
//  busy_o         out  1  1 in every state except IDLE
//  done_o         out  1  1-cycle pulse: frame sent, bus returned to idle
//  err_o          out  1  1-cycle pulse: timeout (or NACK, see CONFIGURATION)
//  ps2_clk_i      in   1  raw PS/2 clock pin (asynchronous)
//  ps2_data_i     in   1  raw PS/2 data pin (asynchronous)
//  ps2_clk_oe_o   out  1  1 = pull clock line low, 0 = release
//  ps2_data_oe_o  out  1  1 = pull data line low, 0 = release
// BEHAVIOUR
//  - Reset (async): state IDLE. tx_ready_o=1; busy_o, done_o, err_o, both oe = 0. Byte register and counters cleared.
//  - Reset mid-frame releases both lines immediately.
//  - Input sync: 2-FF synchronizer on each pin. fall = clk_s1 & ~clk_s0 (registered).
//    A pin edge is seen 3 cycles later. Pin activity is ignored in IDLE.
//  - Accept: on the handshake, latch byte d and par = ~^d (odd parity), enter INHIBIT.
//    tx_ready_o drops the next cycle. tx_valid_i is ignored while busy.
//  - INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles.
//  - START: clk_oe=1, data_oe=1 for 1 cycle.
//  - SEND: clk_oe=0, data_oe=1 (start bit). Edge counter n starts at 0. Each fall increments n and drives:
//    n=1..8: data_oe = ~d[n-1] (LSB first); n=9: data_oe = ~par; n=10: data_oe=0 (stop), then go to ACK.
//  - ACK: on the next fall, sample data_s. Low = ACK. Go to WAIT_IDLE.
//  - WAIT_IDLE: when clk_s=1 and data_s=1, pulse done_o, then IDLE.
//  - Timeout: the counter restarts on entry to SEND and on every fall.
//    Limit is FIRST_TIMEOUT_CYCLES until the first fall, EDGE_TIMEOUT_CYCLES after it.
//    Applies in SEND, ACK and WAIT_IDLE. On expiry: both oe=0 that cycle, pulse err_o, go to IDLE, no done_o.
//  - A fall and a timeout in the same cycle: the fall wins.
//  - done_o and err_o are never asserted together. Each is asserted once per accepted byte.
//  - Open-drain only: the block never drives a pin high.
// CONFIGURATION
//  PS2_TX_ACK_CHECK_EN defined:
//    data_s=1 at the ACK fall (NACK) -> still wait for bus idle, then pulse err_o instead of done_o.
//  PS2_TX_ACK_CHECK_EN undefined:
//    the ACK-edge sample is ignored; done_o always follows bus idle.
// TESTING
//  Bench: FREQ_HZ=1_000_000, INHIBIT_US=4, FIRST_TIMEOUT_US=50, EDGE_TIMEOUT_US=20.
//  Device model: 10-cycle clock half-period, samples data on rising edges.
//  1. Send 0xED -> clk_oe high exactly 4 cycles, then 1 START cycle.
//     Device sees start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Model ACKs -> one done_o, no err_o.
//  2. Send 0x00 -> parity 1. Send 0xFF -> parity 1. Send 0x01 -> parity 0.
//     Device captures all three bytes intact, each followed by done_o.
//  3. Model never clocks -> err_o exactly 50 cycles after SEND entry.
//     Both oe=0, tx_ready_o=1 the next cycle.
//  4. Model stops after 4 edges -> err_o 20 cycles after the 4th fall is seen.
//     A following 0xF4 send completes normally.
//  5. Model NACKs (data high at the ACK fall) -> err_o with the macro defined, done_o without it.
//  6. reset_n_i low mid-SEND -> both oe=0 asynchronously. tx_valid_i held high while busy -> no second accept.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 8 data bits + odd parity + stop, ACK.
// Optional: define PS2_TX_ACK_CHECK_EN to report a device NACK on err_o instead of done_o.
module ps2_host_tx #(
  parameter int FREQ_HZ          = 25_000_000,
  parameter int INHIBIT_US       = 100,
  parameter int FIRST_TIMEOUT_US = 15000,
  parameter int EDGE_TIMEOUT_US  = 2000
) (
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o
);

  localparam int CPU            = FREQ_HZ / 1_000_000;
  localparam int INHIBIT_CYCLES = CPU * INHIBIT_US;
  localparam int FIRST_CYCLES   = CPU * FIRST_TIMEOUT_US;
  localparam int EDGE_CYCLES    = CPU * EDGE_TIMEOUT_US;
  localparam int TMAX0          = (INHIBIT_CYCLES > FIRST_CYCLES) ? INHIBIT_CYCLES : FIRST_CYCLES;
  localparam int TMAX           = (TMAX0 > EDGE_CYCLES) ? TMAX0 : EDGE_CYCLES;
  localparam int CW             = $clog2(TMAX + 1);

  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] FIRST_LAST = CW'(FIRST_CYCLES - 1);
  localparam logic [CW-1:0] EDGE_LAST  = CW'(EDGE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t        state;
  logic [7:0]    d;
  logic          par;
  logic [CW-1:0] tcnt;
  logic [3:0]    n;
  logic          first;
  logic          clk_m, clk_s0, clk_s1, data_m, data_s0, fall;
  logic [CW-1:0] t_lim;
`ifdef PS2_TX_ACK_CHECK_EN
  logic          nack;
`endif

  // Pins idle high, so the synchronizers reset to 1 to avoid a false fall after reset.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      clk_m   <= 1'b1;
      clk_s0  <= 1'b1;
      clk_s1  <= 1'b1;
      data_m  <= 1'b1;
      data_s0 <= 1'b1;
      fall    <= 1'b0;
    end else begin
      clk_m   <= ps2_clk_i;
      clk_s0  <= clk_m;
      clk_s1  <= clk_s0;
      data_m  <= ps2_data_i;
      data_s0 <= data_m;
      fall    <= clk_s1 & ~clk_s0;
    end
  end

  assign t_lim = first ? FIRST_LAST : EDGE_LAST;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state         <= S_IDLE;
      tx_ready_o    <= 1'b1;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      ps2_clk_oe_o  <= 1'b0;
      ps2_data_oe_o <= 1'b0;
      d             <= '0;
      par           <= 1'b0;
      tcnt          <= '0;
      n             <= '0;
      first         <= 1'b1;
`ifdef PS2_TX_ACK_CHECK_EN
      nack          <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_valid_i && tx_ready_o) begin
            d             <= tx_data_i;
            par           <= ~^tx_data_i;
            tcnt          <= '0;
            ps2_clk_oe_o  <= 1'b1;
            ps2_data_oe_o <= 1'b0;
            tx_ready_o    <= 1'b0;
            busy_o        <= 1'b1;
            state         <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (tcnt == INH_LAST) begin
            ps2_data_oe_o <= 1'b1;
            state         <= S_START;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_START: begin
          ps2_clk_oe_o <= 1'b0;
          tcnt         <= '0;
          n            <= '0;
          first        <= 1'b1;
          state        <= S_SEND;
        end
        default: begin
          // SEND / ACK / WAIT_IDLE share the watchdog; a fall always beats an expiry.
          if (state == S_WAIT_IDLE && clk_s0 && data_s0) begin
`ifdef PS2_TX_ACK_CHECK_EN
            done_o <= ~nack;
            err_o  <= nack;
`else
            done_o <= 1'b1;
`endif
            tx_ready_o <= 1'b1;
            busy_o     <= 1'b0;
            state      <= S_IDLE;
          end else if (fall) begin
            tcnt  <= '0;
            first <= 1'b0;
            if (state == S_SEND) begin
              n <= n + 1'b1;
              if (n < 4'd8)
                ps2_data_oe_o <= ~d[n[2:0]];
              else if (n == 4'd8)
                ps2_data_oe_o <= ~par;
              else begin
                ps2_data_oe_o <= 1'b0;
                state         <= S_ACK;
              end
            end else if (state == S_ACK) begin
`ifdef PS2_TX_ACK_CHECK_EN
              nack <= data_s0;
`endif
              state <= S_WAIT_IDLE;
            end
          end else if (tcnt == t_lim) begin
            ps2_clk_oe_o  <= 1'b0;
            ps2_data_oe_o <= 1'b0;
            err_o         <= 1'b1;
            tx_ready_o    <= 1'b1;
            busy_o        <= 1'b0;
            state         <= S_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a PS/2 device model (10-cycle clock half-period).
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       reset_n_i = 1'b0;
  logic [7:0] tx_data_i = '0;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o, busy_o, done_o, err_o;
  logic       ps2_clk_oe_o, ps2_data_oe_o;
  logic       ps2_clk_i, ps2_data_i;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  assign ps2_clk_i  = ~(ps2_clk_oe_o | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe_o | dev_data_low);

  ps2_host_tx #(
    .FREQ_HZ(1_000_000), .INHIBIT_US(4), .FIRST_TIMEOUT_US(50), .EDGE_TIMEOUT_US(20)
  ) dut (
    .clk(clk), .reset_n_i(reset_n_i), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe_o(ps2_clk_oe_o), .ps2_data_oe_o(ps2_data_oe_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          edges;   // device clock falls to generate; 11 = full frame + ACK fall
    bit          ack;
    logic [10:0] frame;   // {stop, parity, data, start}
    bit          check;
  } dev_cmd_t;

  dev_cmd_t dev_q[$];
  bit       exp_q[$];     // 1 = err_o expected, 0 = done_o expected

  int checks = 0, errors = 0;
  int cyc = 0, resp_cnt = 0, err_cyc = 0, send_cyc = 0, fall_cyc = 0, acc_cnt = 0;

  initial forever begin
    @(posedge clk);
    if (tx_valid_i && tx_ready_o && reset_n_i) acc_cnt++;
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard on every done_o/err_o.
  initial forever begin
    @(negedge clk);
    if (done_o || err_o) begin
      chk("done_err_exclusive", 32'(done_o & err_o), 32'd0);
      if (exp_q.size() == 0) chk("unexpected_response", 32'(err_o), 32'hFFFF_FFFF);
      else chk("response_kind", 32'(err_o), 32'(exp_q.pop_front()));
      if (err_o) begin
        err_cyc = cyc;
        chk("oe_released_at_err", {30'd0, ps2_clk_oe_o, ps2_data_oe_o}, 32'd0);
      end
      resp_cnt++;
    end
  end

  // Inhibit/start phase lengths, checked when SEND begins.
  initial begin
    int inh, st;
    inh = 0; st = 0;
    forever begin
      @(negedge clk);
      if (!busy_o) begin inh = 0; st = 0; end
      else if (ps2_clk_oe_o && !ps2_data_oe_o) inh++;
      else if (ps2_clk_oe_o && ps2_data_oe_o) st++;
      else if (!ps2_clk_oe_o && ps2_data_oe_o && (inh != 0 || st != 0)) begin
        chk("inhibit_cycles", 32'(inh), 32'd4);
        chk("start_cycles", 32'(st), 32'd1);
        send_cyc = cyc;
        inh = 0; st = 0;
      end
    end
  end

  // Device model: reacts to request-to-send, clocks the frame, samples data on each rise.
  initial forever begin
    @(negedge clk);
    if (busy_o && !ps2_clk_oe_o && ps2_data_oe_o && ps2_clk_i) begin
      dev_cmd_t c;
      logic [10:0] cap;
      if (dev_q.size() == 0) begin
        chk("unexpected_frame", 32'd1, 32'd0);
      end else begin
        c = dev_q.pop_front();
        cap = '1;
        repeat (5) @(negedge clk);
        cap[0] = ps2_data_i;
        for (int i = 1; i <= c.edges; i++) begin
          repeat (5) @(negedge clk);
          if (i == 11 && c.ack) dev_data_low = 1'b1;
          repeat (5) @(negedge clk);
          dev_clk_low = 1'b1;
          fall_cyc = cyc;
          repeat (10) @(negedge clk);
          dev_clk_low = 1'b0;
          if (i <= 10) cap[i] = ps2_data_i;
        end
        dev_data_low = 1'b0;
        if (c.check) chk("device_frame", 32'(cap), 32'(c.frame));
      end
      for (int t = 0; t < 200 && busy_o; t++) @(negedge clk);
      if (busy_o) chk("device_wait_idle", 32'd1, 32'd0);
    end
  end

  task automatic send(input logic [7:0] d, input bit par, input int edges, input bit ack,
                      input bit exp_valid, input bit exp_err, input bit hold);
    dev_cmd_t c;
    c.edges = edges;
    c.ack   = ack;
    c.frame = {1'b1, par, d, 1'b0};
    c.check = (edges == 11);
    dev_q.push_back(c);
    if (exp_valid) exp_q.push_back(exp_err);
    @(negedge clk);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    @(negedge clk);
    chk("ready_drops", 32'(tx_ready_o), 32'd0);
    chk("busy_rises", 32'(busy_o), 32'd1);
    if (!hold) tx_valid_i = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    for (int t = 0; t < 800 && resp_cnt < target; t++) @(negedge clk);
    if (resp_cnt < target) chk("response_timeout", 32'(resp_cnt), 32'(target));
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [7:0] vec_d [3] = '{8'h00, 8'hFF, 8'h01};
  bit         vec_p [3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    int nr, acc0;
    bit nack_err;
`ifdef PS2_TX_ACK_CHECK_EN
    nack_err = 1'b1;
`else
    nack_err = 1'b0;
`endif
    nr = 0;
    repeat (3) @(negedge clk);
    chk("reset_state", {26'd0, tx_ready_o, busy_o, done_o, err_o, ps2_clk_oe_o, ps2_data_oe_o},
        32'b100000);
    reset_n_i = 1'b1;
    repeat (5) @(negedge clk);

    // 1: 0xED, parity 1, ACKed
    send(8'hED, 1'b1, 11, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_resp(++nr);

    // 2: parity corner bytes
    for (int i = 0; i < 3; i++) begin
      send(vec_d[i], vec_p[i], 11, 1'b1, 1'b1, 1'b0, 1'b0);
      wait_resp(++nr);
    end

    // 3: device never clocks -> first-edge timeout
    send(8'hA5, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_resp(++nr);
    chk("first_timeout_cycles", 32'(err_cyc - send_cyc), 32'd50);
    chk("idle_after_err", {29'd0, tx_ready_o, ps2_clk_oe_o, ps2_data_oe_o}, 32'b100);

    // 4: device stops after 4 falls -> edge timeout; pin fall is seen by the FSM 4 cycles later
    send(8'h5A, 1'b1, 4, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_resp(++nr);
    chk("edge_timeout_cycles", 32'(err_cyc - fall_cyc), 32'd24);
    send(8'hF4, 1'b0, 11, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_resp(++nr);

    // 5: NACK
    send(8'hF3, 1'b1, 11, 1'b0, 1'b1, nack_err, 1'b0);
    wait_resp(++nr);

    // 6a: async reset in the middle of SEND
    send(8'h12, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 20 && !(!ps2_clk_oe_o && ps2_data_oe_o); t++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("in_send_before_reset", {30'd0, ps2_clk_oe_o, ps2_data_oe_o}, 32'b01);
    #2 reset_n_i = 1'b0;
    #1 chk("reset_releases_lines", {29'd0, ps2_clk_oe_o, ps2_data_oe_o, busy_o}, 32'd0);
    @(negedge clk);
    reset_n_i = 1'b1;
    repeat (10) @(negedge clk);

    // 6b: tx_valid_i held high while busy -> exactly one accept
    acc0 = acc_cnt;
    send(8'hAB, 1'b0, 11, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (150) @(negedge clk);
    tx_valid_i = 1'b0;
    wait_resp(++nr);
    repeat (20) @(negedge clk);
    chk("single_accept", 32'(acc_cnt - acc0), 32'd1);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("device_queue_drained", 32'(dev_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
